// File: rtl/boreal_sha_arbiter.sv
// boreal_sha_arbiter: lock-based arbiter sharing one SHA-256 engine between
// NREQ requesters. Requester 0 (boot ROM) may be given absolute priority;
// otherwise grants rotate round-robin. The engine is drained before each
// handover, and owners that stall for TIMEOUT cycles lose their grant.
module boreal_sha_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TMO_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      rel,
    input  logic [NREQ-1:0]      req_start,
    input  logic [NREQ-1:0]      req_update,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic                 boot_priority,
    input  logic                 clr_err,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_hash,
    output logic                 sha_start,
    output logic                 sha_update,
    output logic [31:0]          sha_data,
    input  logic [31:0]          sha_hash,
    input  logic                 sha_ready,
    output logic [IDX_W-1:0]     owner_id,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [IDX_W-1:0]     timeout_id
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN
    } state_t;

    state_t             state, state_nxt;
    logic [NREQ-1:0]    gnt_nxt;
    logic [IDX_W-1:0]   owner_nxt;
    logic [IDX_W-1:0]   last, last_nxt;
    logic [IDX_W-1:0]   tid_nxt;
    logic [TMO_W-1:0]   tmo, tmo_nxt;
    logic               err_nxt;

    logic [IDX_W-1:0]   win;
    logic               win_found;
    int unsigned        cand;

    logic               own_req, own_rel, own_start, own_update, own_act;
    logic [31:0]        own_data;

    // Select the current owner's request/release/traffic signals.
    always_comb begin
        own_req    = 1'b0;
        own_rel    = 1'b0;
        own_start  = 1'b0;
        own_update = 1'b0;
        own_data   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_id == IDX_W'(i)) begin
                own_req    = req[i];
                own_rel    = rel[i];
                own_start  = req_start[i];
                own_update = req_update[i];
                own_data   = req_data[32*i +: 32];
            end
        end
        own_act = own_start | own_update;
    end

    // Pick the arbitration winner: boot priority, else round-robin after last.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 32'(last) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = IDX_W'(cand);
            end
        end
        if (boot_priority && req[0]) begin
            win = '0;
        end
    end

    // Engine-side and response muxing: only the owner in GRANT gets through.
    always_comb begin
        sha_start  = 1'b0;
        sha_update = 1'b0;
        sha_data   = '0;
        rsp_ready  = '0;
        rsp_hash   = '0;
        if (state == GRANT) begin
            sha_start  = own_start;
            sha_update = own_update;
            sha_data   = own_data;
            rsp_ready  = gnt & {NREQ{sha_ready}};
            rsp_hash   = sha_hash;
        end
    end

    assign busy = (state != IDLE);

    // Next-state logic for arbitration, ownership, timeout and error flag.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner_id;
        last_nxt  = last;
        tmo_nxt   = tmo;
        tid_nxt   = timeout_id;
        err_nxt   = clr_err ? 1'b0 : timeout_err;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_nxt = GRANT;
                    gnt_nxt   = '0;
                    gnt_nxt[win] = 1'b1;
                    owner_nxt = win;
                    last_nxt  = win;
                    tmo_nxt   = '0;
                end
            end
            GRANT: begin
                tmo_nxt = own_act ? '0 : tmo + 1'b1;
                // Normal release takes precedence over a coincident timeout.
                if (own_rel || !own_req) begin
                    state_nxt = DRAIN;
                    gnt_nxt   = '0;
                end else if (!own_act && tmo == TMO_W'(TIMEOUT - 1)) begin
                    state_nxt = DRAIN;
                    gnt_nxt   = '0;
                    err_nxt   = 1'b1;
                    tid_nxt   = owner_id;
                end
            end
            DRAIN: begin
                gnt_nxt = '0;
                if (sha_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            owner_id    <= '0;
            last        <= IDX_W'(NREQ - 1);
            tmo         <= '0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            owner_id    <= owner_nxt;
            last        <= last_nxt;
            tmo         <= tmo_nxt;
            timeout_err <= err_nxt;
            timeout_id  <= tid_nxt;
        end
    end

endmodule
